// File: rtl/abr_mem_arb.sv
// Round-robin arbiter sharing one ABR memory instance among NUM_REQ requesters.
// Optional grant locking is enabled by defining ABR_MEM_ARB_LOCK_EN.
module abr_mem_arb #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 96,
  parameter int RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [2*NUM_REQ-1:0]      req_rw_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  input  logic [NUM_REQ-1:0]        req_lock_i,
  output logic [NUM_REQ-1:0]        req_gnt_o,
  output logic [NUM_REQ-1:0]        rsp_rvalid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic [1:0]                mem_rw_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic [DATA_W-1:0]         mem_rdata_i,
  output logic                      busy_o
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NUM_REQ - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  logic [NUM_REQ-1:0] elig_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic               gnt_any_s;
  logic [PTR_W-1:0]   gnt_idx_s;
  logic               rr_any_s;
  logic [PTR_W-1:0]   rr_idx_s;
  logic [PTR_W-1:0]   cand_s;
  logic [1:0]         gnt_rw_s;
  logic [ADDR_W-1:0]  gnt_addr_s;
  logic [DATA_W-1:0]  gnt_wdata_s;
  logic               gnt_lock_s;
  logic               tag_any_s;
  logic [PTR_W-1:0]   rr_ptr_r;
  logic [1:0]         mem_rw_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [DATA_W-1:0]  mem_wdata_r;
  logic [NUM_REQ-1:0] tag_r [RD_LATENCY+1];

`ifdef ABR_MEM_ARB_LOCK_EN
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;
  lock_state_e        lock_state_r;
  logic [PTR_W-1:0]   owner_r;
`else
  logic               unused_lock_s;
  assign unused_lock_s = ^req_lock_i;
`endif

  // Eligibility: valid request carrying a read or write command.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid_i[i] && (req_rw_i[2*i +: 2] == RW_READ || req_rw_i[2*i +: 2] == RW_WRITE)) begin
        elig_s[i] = 1'b1;
      end else begin
        elig_s[i] = 1'b0;
      end
    end
  end

  // Round-robin search starting at rr_ptr_r.
  always_comb begin
    rr_any_s = 1'b0;
    rr_idx_s = '0;
    cand_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = PTR_W'((int'(rr_ptr_r) + k) % NUM_REQ);
      if (!rr_any_s && elig_s[cand_s]) begin
        rr_any_s = 1'b1;
        rr_idx_s = cand_s;
      end else begin
        rr_any_s = rr_any_s;
      end
    end
  end

  // Final grant: a held lock overrides round-robin; reset blocks all grants.
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_idx_s = '0;
`ifdef ABR_MEM_ARB_LOCK_EN
    if (lock_state_r == LOCKED) begin
      gnt_any_s = elig_s[owner_r];
      gnt_idx_s = owner_r;
    end else begin
      gnt_any_s = rr_any_s;
      gnt_idx_s = rr_idx_s;
    end
`else
    gnt_any_s = rr_any_s;
    gnt_idx_s = rr_idx_s;
`endif
    if (rst) begin
      gnt_any_s = 1'b0;
    end else begin
      gnt_any_s = gnt_any_s;
    end
    if (gnt_any_s) begin
      gnt_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx_s;
    end else begin
      gnt_s = '0;
    end
  end

  assign req_gnt_o = gnt_s;

  // Select the granted requester's command, address, data and lock request.
  always_comb begin
    gnt_rw_s    = RW_IDLE;
    gnt_addr_s  = '0;
    gnt_wdata_s = '0;
    gnt_lock_s  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx_s == PTR_W'(i)) begin
        gnt_rw_s    = req_rw_i[2*i +: 2];
        gnt_addr_s  = req_addr_i[i*ADDR_W +: ADDR_W];
        gnt_wdata_s = req_wdata_i[i*DATA_W +: DATA_W];
        gnt_lock_s  = req_lock_i[i];
      end else begin
        gnt_lock_s = gnt_lock_s;
      end
    end
  end

  // Memory command register: address and data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rw_r    <= RW_IDLE;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else if (gnt_any_s) begin
      mem_rw_r    <= gnt_rw_s;
      mem_addr_r  <= gnt_addr_s;
      mem_wdata_r <= gnt_wdata_s;
    end else begin
      mem_rw_r    <= RW_IDLE;
    end
  end

  assign mem_rw_o    = mem_rw_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;

  // Requester-tag pipeline: the last stage lines up with returning read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= RD_LATENCY; k++) begin
        tag_r[k] <= '0;
      end
    end else begin
      if (gnt_any_s && gnt_rw_s == RW_READ) begin
        tag_r[0] <= gnt_s;
      end else begin
        tag_r[0] <= '0;
      end
      for (int k = 1; k <= RD_LATENCY; k++) begin
        tag_r[k] <= tag_r[k-1];
      end
    end
  end

  // Any read still in flight.
  always_comb begin
    tag_any_s = 1'b0;
    for (int k = 0; k <= RD_LATENCY; k++) begin
      tag_any_s = tag_any_s | (|tag_r[k]);
    end
  end

  assign rsp_rvalid_o = tag_r[RD_LATENCY];
  assign rsp_rdata_o  = mem_rdata_i;

`ifdef ABR_MEM_ARB_LOCK_EN
  // Lock FSM and round-robin pointer; a dropped lock hands priority past the owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state_r <= UNLOCKED;
      owner_r      <= '0;
      rr_ptr_r     <= '0;
    end else begin
      case (lock_state_r)
        UNLOCKED: begin
          if (gnt_any_s) begin
            rr_ptr_r <= next_ptr(gnt_idx_s);
            if (gnt_lock_s) begin
              lock_state_r <= LOCKED;
              owner_r      <= gnt_idx_s;
            end else begin
              lock_state_r <= UNLOCKED;
            end
          end else begin
            rr_ptr_r <= rr_ptr_r;
          end
        end
        LOCKED: begin
          rr_ptr_r <= next_ptr(owner_r);
          if (gnt_any_s && gnt_lock_s) begin
            lock_state_r <= LOCKED;
          end else begin
            lock_state_r <= UNLOCKED;
          end
        end
        default: begin
          lock_state_r <= UNLOCKED;
          rr_ptr_r     <= '0;
        end
      endcase
    end
  end

  assign busy_o = (lock_state_r == LOCKED) | tag_any_s;
`else
  // Round-robin pointer advances past every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else if (gnt_any_s) begin
      rr_ptr_r <= next_ptr(gnt_idx_s);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  assign busy_o = tag_any_s;
`endif

endmodule

// File: tb/tb_abr_mem_arb.sv
// Randomized bench for abr_mem_arb (NUM_REQ=3, RD_LATENCY=1) against a behavioural model.
module tb_abr_mem_arb;

  localparam int N   = 3;
  localparam int AW  = 14;
  localparam int DW  = 96;
  localparam int LAT = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid_i;
  logic [2*N-1:0]  req_rw_i;
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [N-1:0]    req_lock_i;
  logic [N-1:0]    req_gnt_o;
  logic [N-1:0]    rsp_rvalid_o;
  logic [DW-1:0]   rsp_rdata_o;
  logic [1:0]      mem_rw_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o;
  logic [DW-1:0]   mem_rdata_i;
  logic            busy_o;

  always #5 clk = ~clk;

  abr_mem_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_rw_i(req_rw_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_lock_i(req_lock_i), .req_gnt_o(req_gnt_o),
    .rsp_rvalid_o(rsp_rvalid_o), .rsp_rdata_o(rsp_rdata_o), .mem_rw_o(mem_rw_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Reference model state
  int          m_rr = 0;
  bit          m_locked = 1'b0;
  int          m_owner = 0;
  logic [1:0]  m_rw = 2'b00;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [N-1:0]  m_sched [8];
  int          cyc = 0;
  int          last_gnt = -1;
  int          seq [8];

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] v, input logic [2*N-1:0] rw);
    bit el [N];
    for (int i = 0; i < N; i++) begin
      el[i] = v[i] && (rw[2*i +: 2] == 2'b01 || rw[2*i +: 2] == 2'b10);
    end
    if (m_locked) return el[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (el[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N*AW-1:0] rnd_addr();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [N*DW-1:0] rnd_wdata();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N*DW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic step(input bit r, input logic [N-1:0] v, input logic [2*N-1:0] rw,
                      input logic [N-1:0] lk, input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    int g;
    bit busy_exp;
    logic [N-1:0] gexp;
    @(negedge clk);
    rst = r; req_valid_i = v; req_rw_i = rw; req_lock_i = lk;
    req_addr_i = a; req_wdata_i = d;
    mem_rdata_i = {$urandom, $urandom, $urandom};
    #1;
    g = r ? -1 : model_pick(v, rw);
    last_gnt = g;
    gexp = (g < 0) ? '0 : (N'(1) << g);
    chk("gnt", req_gnt_o, gexp);
    chk("rdata", rsp_rdata_o, mem_rdata_i);
    if (r) begin
      m_rr = 0; m_locked = 1'b0; m_owner = 0;
      m_rw = 2'b00; m_addr = '0; m_wdata = '0;
      for (int k = 0; k < 8; k++) m_sched[k] = '0;
    end else begin
      if (g >= 0) begin
        m_rw = rw[2*g +: 2];
        m_addr = a[g*AW +: AW];
        m_wdata = d[g*DW +: DW];
        if (m_rw == 2'b01) m_sched[(cyc + 1 + LAT) % 8] |= N'(1) << g;
      end else begin
        m_rw = 2'b00;
      end
`ifdef ABR_MEM_ARB_LOCK_EN
      if (m_locked) begin
        m_rr = (m_owner + 1) % N;
        if (g < 0 || !lk[m_owner]) m_locked = 1'b0;
      end else if (g >= 0) begin
        m_rr = (g + 1) % N;
        if (lk[g]) begin
          m_locked = 1'b1;
          m_owner = g;
        end
      end
`else
      if (g >= 0) m_rr = (g + 1) % N;
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
    busy_exp = m_locked;
    for (int k = 0; k < 8; k++) busy_exp = busy_exp | (|m_sched[k]);
    chk("mem_rw", mem_rw_o, m_rw);
    chk("mem_addr", mem_addr_o, m_addr);
    chk("mem_wdata", mem_wdata_o, m_wdata);
    chk("rvalid", rsp_rvalid_o, m_sched[cyc % 8]);
    chk("busy", busy_o, busy_exp);
    m_sched[cyc % 8] = '0;
  endtask

  initial begin
    int exp_seq [5];
    for (int k = 0; k < 8; k++) m_sched[k] = '0;
    rst = 1'b1; req_valid_i = '0; req_rw_i = '0; req_lock_i = '0;
    req_addr_i = '0; req_wdata_i = '0; mem_rdata_i = '0;

    step(1'b1, 3'b000, 6'b0, 3'b000, '0, '0);
    step(1'b1, 3'b111, 6'b010101, 3'b000, rnd_addr(), rnd_wdata());

    // Continuous reads from all three requesters rotate 0,1,2,0,1,2
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 3'b111, 6'b010101, 3'b000, rnd_addr(), rnd_wdata());
      seq[i] = last_gnt;
    end
    for (int i = 0; i < 6; i++) chk("rr_seq", 128'(seq[i]), 128'(i % 3));
    for (int i = 0; i < 3; i++) step(1'b0, 3'b000, 6'b0, 3'b000, rnd_addr(), rnd_wdata());

    // Write from requester 1
    step(1'b0, 3'b010, 6'b001000, 3'b000, {14'h0000, 14'h0123, 14'h0000},
         {96'h0, {12{8'hA5}}, 96'h0});
    chk("wr_rw", mem_rw_o, 2'b10);
    chk("wr_addr", mem_addr_o, 14'h0123);
    chk("wr_wdata", mem_wdata_o, {12{8'hA5}});
    chk("wr_rvalid", rsp_rvalid_o, 3'b000);

    // Illegal command 2'b11 is never granted
    step(1'b0, 3'b001, 6'b000011, 3'b000, rnd_addr(), rnd_wdata());
    chk("rw11_idle", mem_rw_o, 2'b00);

    // Lock scenario: rr pointer parked at 2, then requester 2 asks for 4 beats
    step(1'b1, 3'b000, 6'b0, 3'b000, '0, '0);
    step(1'b0, 3'b010, 6'b000100, 3'b000, rnd_addr(), rnd_wdata());
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 3'b111, 6'b010101, (i < 3) ? 3'b100 : 3'b000, rnd_addr(), rnd_wdata());
      seq[i] = last_gnt;
    end
`ifdef ABR_MEM_ARB_LOCK_EN
    exp_seq = '{2, 2, 2, 2, 0};
`else
    exp_seq = '{2, 0, 1, 2, 0};
`endif
    for (int i = 0; i < 5; i++) chk("lock_seq", 128'(seq[i]), 128'(exp_seq[i]));

    // Reset while a read is in flight discards it
    step(1'b0, 3'b001, 6'b000001, 3'b000, rnd_addr(), rnd_wdata());
    step(1'b1, 3'b000, 6'b0, 3'b000, '0, '0);
    chk("rst_busy", busy_o, 1'b0);
    step(1'b0, 3'b000, 6'b0, 3'b000, rnd_addr(), rnd_wdata());
    chk("rst_rvalid", rsp_rvalid_o, 3'b000);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), 3'($urandom), 6'($urandom),
           3'($urandom & $urandom), rnd_addr(), rnd_wdata());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/abr_mem_arb.md
ABR_MEM_ARB -- requirements
Module: abr_mem_arb

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requesters sharing one memory instance (legal 2..4).
REQ-002 Parameter ADDR_W, default 14: memory address width (ABR_MEM_ADDR_WIDTH, including 3 bank-select bits).
REQ-003 Parameter DATA_W, default 96: memory data width (ABR_MEM_DATA_WIDTH, 4 coefficients x 24 bits).
REQ-004 Parameter RD_LATENCY, default 1: memory read latency in cycles (legal 1..2).
REQ-005 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port req_valid_i, input, NUM_REQ: per-requester access request.
REQ-008 Port req_rw_i, input, 2*NUM_REQ: per-requester mem_rw_mode_e (RW_IDLE=00, RW_READ=01, RW_WRITE=10).
REQ-009 Port req_addr_i, input, NUM_REQ*ADDR_W: per-requester address.
REQ-010 Port req_wdata_i, input, NUM_REQ*DATA_W: per-requester write data.
REQ-011 Port req_lock_i, input, NUM_REQ: requester asks to keep the grant for its next access.
REQ-012 Port req_gnt_o, output, NUM_REQ: one-hot grant; the request is accepted in the cycle it is high.
REQ-013 Port rsp_rvalid_o, output, NUM_REQ: one-hot read-data-valid to the requester that issued the read.
REQ-014 Port rsp_rdata_o, output, DATA_W: read data, broadcast to all requesters.
REQ-015 Port mem_rw_o, output, 2: registered memory command (mem_rw_mode_e).
REQ-016 Port mem_addr_o, output, ADDR_W: registered memory address.
REQ-017 Port mem_wdata_o, output, DATA_W: registered memory write data.
REQ-018 Port mem_rdata_i, input, DATA_W: memory read data.
REQ-019 Port busy_o, output, 1: high while a lock is held or any read is in flight.

Function
REQ-020 A requester is eligible when req_valid_i[i]=1 and req_rw_i[i] is RW_READ or RW_WRITE; RW_IDLE and 2'b11 are never granted.
REQ-021 req_gnt_o is combinational, at most one bit high, and only toward an eligible requester.
REQ-022 Round-robin: search starts at rr_ptr; the first eligible index (rr_ptr, rr_ptr+1, ... mod NUM_REQ) is granted.
REQ-023 After an unlocked grant to i, rr_ptr becomes (i+1) mod NUM_REQ; with no grant, rr_ptr holds.
REQ-024 Grant in cycle t drives mem_rw_o/mem_addr_o/mem_wdata_o in cycle t+1; with no grant, mem_rw_o=RW_IDLE, mem_addr_o and mem_wdata_o hold.
REQ-025 A read granted in cycle t asserts rsp_rvalid_o[i] exactly in cycle t+1+RD_LATENCY.
REQ-026 rsp_rdata_o equals mem_rdata_i combinationally; it is only meaningful when a rsp_rvalid_o bit is high.
REQ-027 An RD_LATENCY+1 stage requester-tag pipeline tracks reads; back-to-back reads from different requesters each return in order, one per cycle.
REQ-028 Writes produce no rsp_rvalid_o.
REQ-029 Lock state machine: states UNLOCKED and LOCKED(owner).
REQ-030 UNLOCKED -> LOCKED(i) when i is granted with req_lock_i[i]=1.
REQ-031 In LOCKED(i), only i may be granted, regardless of other requesters or rr_ptr.
REQ-032 LOCKED(i) -> UNLOCKED when i is granted with req_lock_i[i]=0 (last beat), or when i is not eligible in a cycle; rr_ptr then becomes (i+1) mod NUM_REQ.
REQ-033 busy_o = LOCKED or any tag pipeline stage valid.

Reset
REQ-034 While rst=1 at a clock edge: rr_ptr=0, state UNLOCKED, tag pipeline cleared, mem_rw_o=RW_IDLE, mem_addr_o=0, mem_wdata_o=0.
REQ-035 While rst=1, req_gnt_o=0; in the cycle after reset, rsp_rvalid_o=0 and busy_o=0.
REQ-036 Reset mid-operation discards in-flight reads (no rsp_rvalid_o for them) and releases any lock.

Configuration
REQ-037 Macro ABR_MEM_ARB_LOCK_EN defined: lock behaviour per REQ-029..REQ-032.
REQ-038 Macro ABR_MEM_ARB_LOCK_EN undefined: req_lock_i is ignored, no lock state exists, pure per-cycle round-robin, and busy_o reflects in-flight reads only.

Verification
REQ-039 Reset, then all three requesters valid with RW_READ continuously -> grants 0,1,2,0,1,2; rsp_rvalid_o 0,1,2 at cycles t+2, t+3, t+4 (RD_LATENCY=1).
REQ-040 Requester 1 RW_WRITE addr 0x0123, wdata 0xA5..A5 -> mem_rw_o=10, mem_addr_o=0x0123 next cycle; no rsp_rvalid_o.
REQ-041 With LOCK_EN: requester 2 locks for 4 beats while 0 and 1 request -> gnt[2] for 4 consecutive cycles, then gnt[0].
REQ-042 Requester 0 valid with rw=2'b11 and requester 1 idle -> no grant, mem_rw_o=RW_IDLE.
REQ-043 RD_LATENCY=2: read granted at t, rst asserted at t+1 -> no rsp_rvalid_o at t+3, busy_o=0 after reset.
REQ-044 Without LOCK_EN: same stimulus as REQ-041 -> grants rotate 2,0,1,2 each cycle.
